microstep_sequencer: RTL and testbench

Parametrised successor to the fixed-length T-state ring counter in the SAP-1.5 control path.
- Sequences fetch and execute microsteps with variable-length instructions: an instruction such as NOP ends as soon as the decoder flags its last step.
- Supports free-run and single-step modes, HLT with resume, and a saturating retired-instruction counter.
- Sits between the instruction register/microcode decoder and the control-word ROM; it drives the step index the decoder consumes.

---
 rtl/arch_defs_pkg.sv | 15 +
 rtl/sat_counter.sv | 26 ++
 rtl/microstep_sequencer.sv | 110 +++++++++++
 tb/tb_microstep_sequencer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/arch_defs_pkg.sv
// Shared architecture definitions for the SAP control path: sequencer states and
// default instruction-length constants agreed between decoder and sequencer.
package arch_defs_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } seq_state_t;

    localparam int DEF_MAX_STEPS   = 8;
    localparam int DEF_FETCH_STEPS = 2;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; synchronous clear.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clear,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign count = count_q;

endmodule

// File: rtl/microstep_sequencer.sv
// Variable-length microstep sequencer: fetch/execute step index, free-run and
// single-step modes, HLT/resume, retired-instruction counting and overrun flag.
module microstep_sequencer
    import arch_defs_pkg::*;
#(
    parameter  int MAX_STEPS   = DEF_MAX_STEPS,
    parameter  int FETCH_STEPS = DEF_FETCH_STEPS,
    parameter  int COUNT_WIDTH = 16,
    localparam int STEP_WIDTH  = $clog2(MAX_STEPS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   run_mode,
    input  logic                   step_pulse,
    input  logic                   decode_last,
    input  logic                   halt_req,
    input  logic                   resume,
    output logic [STEP_WIDTH-1:0]  step_out,
    output logic                   phase_fetch,
    output logic                   phase_exec,
    output logic                   halted,
    output logic                   instr_done,
    output logic [COUNT_WIDTH-1:0] instr_count,
    output logic                   step_overrun
);

    localparam logic [STEP_WIDTH-1:0] LAST_STEP  = STEP_WIDTH'(MAX_STEPS - 1);
    localparam logic [STEP_WIDTH-1:0] FETCH_LAST = STEP_WIDTH'(FETCH_STEPS - 1);
    localparam logic [STEP_WIDTH-1:0] STEP_ONE   = STEP_WIDTH'(1);

    seq_state_t            state_q;
    logic [STEP_WIDTH-1:0] step_q;
    logic                  done_q;
    logic                  overrun_q;
    logic                  retire_d;

    // An instruction retires on the edge that leaves S_EXEC, whether by HLT,
    // decoder end flag or the step ceiling.
    assign retire_d = (state_q == S_EXEC) &&
                      (halt_req || decode_last || (step_q == LAST_STEP));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            step_q    <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    step_q <= '0;
                    if (run_mode || step_pulse) begin
                        state_q <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    step_q <= step_q + STEP_ONE;
                    if (step_q == FETCH_LAST) begin
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (halt_req) begin
                        state_q <= S_HALT;
                        step_q  <= '0;
                        done_q  <= 1'b1;
                    end else if (decode_last || (step_q == LAST_STEP)) begin
                        state_q <= run_mode ? S_FETCH : S_IDLE;
                        step_q  <= '0;
                        done_q  <= 1'b1;
                        if (!decode_last) begin
                            overrun_q <= 1'b1;
                        end
                    end else begin
                        step_q <= step_q + STEP_ONE;
                    end
                end
                S_HALT: begin
                    step_q <= '0;
                    if (resume) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    step_q  <= '0;
                end
            endcase
        end
    end

    sat_counter #(
        .WIDTH (COUNT_WIDTH)
    ) u_retired (
        .clk   (clk),
        .rst_n (reset),
        .inc   (retire_d),
        .clear (1'b0),
        .count (instr_count)
    );

    assign step_out     = step_q;
    assign phase_fetch  = (state_q == S_FETCH);
    assign phase_exec   = (state_q == S_EXEC);
    assign halted       = (state_q == S_HALT);
    assign instr_done   = done_q;
    assign step_overrun = overrun_q;

endmodule

// File: tb/tb_microstep_sequencer.sv
// Directed cycle-by-cycle checks of the microstep sequencer, with a second
// instance using a 4-bit counter to exercise saturation.
module tb_microstep_sequencer;

    localparam int PI = 0;
    localparam int PF = 1;
    localparam int PE = 2;
    localparam int PH = 3;

    typedef struct {
        logic rm, sp, dl, hr, rs;
        int   e_step;
        int   e_ph;
        logic e_done;
        int   e_cnt;
        logic e_ovr;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        run_mode, step_pulse, decode_last, halt_req, resume;

    logic [2:0]  step_out;
    logic        phase_fetch, phase_exec, halted, instr_done, step_overrun;
    logic [15:0] instr_count;

    logic [2:0]  s_step;
    logic        s_pf, s_pe, s_h, s_done, s_ovr;
    logic [3:0]  s_count;

    int tests_run = 0;
    int tests_failed = 0;
    int done_tally = 0;

    vec_t tbl [27];

    microstep_sequencer #(.MAX_STEPS(8), .FETCH_STEPS(2), .COUNT_WIDTH(16)) dut (
        .clk(clk), .reset(rst_n), .run_mode(run_mode), .step_pulse(step_pulse),
        .decode_last(decode_last), .halt_req(halt_req), .resume(resume),
        .step_out(step_out), .phase_fetch(phase_fetch), .phase_exec(phase_exec),
        .halted(halted), .instr_done(instr_done), .instr_count(instr_count),
        .step_overrun(step_overrun)
    );

    microstep_sequencer #(.MAX_STEPS(8), .FETCH_STEPS(2), .COUNT_WIDTH(4)) dut_small (
        .clk(clk), .reset(rst_n), .run_mode(run_mode), .step_pulse(step_pulse),
        .decode_last(decode_last), .halt_req(halt_req), .resume(resume),
        .step_out(s_step), .phase_fetch(s_pf), .phase_exec(s_pe),
        .halted(s_h), .instr_done(s_done), .instr_count(s_count),
        .step_overrun(s_ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rm, sp, dl, hr, rs, input int st, input int ph,
                                input logic dn, input int cnt, input logic ovr);
        vec_t v;
        v.rm = rm; v.sp = sp; v.dl = dl; v.hr = hr; v.rs = rs;
        v.e_step = st; v.e_ph = ph; v.e_done = dn; v.e_cnt = cnt; v.e_ovr = ovr;
        return v;
    endfunction

    // Called at a negedge: drive inputs, take the rising edge, check 1 ns later.
    task automatic apply(input vec_t v, input string tag);
        int sc;
        logic [7:0] s_exp;
        run_mode = v.rm; step_pulse = v.sp; decode_last = v.dl;
        halt_req = v.hr; resume = v.rs;
        @(posedge clk);
        #1;
        chk({tag, " step_out"},     int'(step_out),     v.e_step);
        chk({tag, " phase_fetch"},  int'(phase_fetch),  int'(v.e_ph == PF));
        chk({tag, " phase_exec"},   int'(phase_exec),   int'(v.e_ph == PE));
        chk({tag, " halted"},       int'(halted),       int'(v.e_ph == PH));
        chk({tag, " instr_done"},   int'(instr_done),   int'(v.e_done));
        chk({tag, " instr_count"},  int'(instr_count),  v.e_cnt);
        chk({tag, " step_overrun"}, int'(step_overrun), int'(v.e_ovr));
        sc = (v.e_cnt > 15) ? 15 : v.e_cnt;
        chk({tag, " small_count"},  int'(s_count),      sc);
        s_exp = {3'(v.e_step), v.e_ph == PF, v.e_ph == PE, v.e_ph == PH, v.e_done, v.e_ovr};
        chk({tag, " small_outputs"}, int'({s_step, s_pf, s_pe, s_h, s_done, s_ovr}), int'(s_exp));
        if (s_done) done_tally++;
        @(negedge clk);
    endtask

    task automatic cyc(input logic rm, sp, dl, hr, rs, input int st, input int ph,
                       input logic dn, input int cnt, input logic ovr, input string tag);
        apply(mk(rm, sp, dl, hr, rs, st, ph, dn, cnt, ovr), tag);
    endtask

    initial begin
        int k;
        // Free-run: five NOPs, one LDI-length instruction, then HLT and resume.
        k = 0;
        tbl[k++] = mk(1,0,0,0,0, 0,PF,0,0,0);
        for (int n = 1; n <= 5; n++) begin
            tbl[k++] = mk(1,0,0,0,0, 1,PF,0,n-1,0);
            tbl[k++] = mk(1,0,0,0,0, 2,PE,0,n-1,0);
            tbl[k++] = mk(1,0,1,0,0, 0,PF,1,n,0);
        end
        tbl[k++] = mk(1,0,0,0,0, 1,PF,0,5,0);
        tbl[k++] = mk(1,0,0,0,0, 2,PE,0,5,0);
        tbl[k++] = mk(1,0,0,0,0, 3,PE,0,5,0);
        tbl[k++] = mk(1,0,0,0,0, 4,PE,0,5,0);
        tbl[k++] = mk(1,0,1,0,0, 0,PF,1,6,0);
        tbl[k++] = mk(1,0,0,0,0, 1,PF,0,6,0);
        tbl[k++] = mk(1,0,0,0,0, 2,PE,0,6,0);
        tbl[k++] = mk(1,0,0,1,0, 0,PH,1,7,0);
        tbl[k++] = mk(1,1,1,1,0, 0,PH,0,7,0);
        tbl[k++] = mk(0,0,0,0,1, 0,PI,0,7,0);
        tbl[k++] = mk(0,0,0,0,0, 0,PI,0,7,0);

        rst_n = 1'b0;
        run_mode = 0; step_pulse = 0; decode_last = 0; halt_req = 0; resume = 0;
        #2;
        chk("reset step_out", int'(step_out), 0);
        chk("reset phase", int'({phase_fetch, phase_exec, halted}), 0);
        chk("reset instr_done", int'(instr_done), 0);
        chk("reset instr_count", int'(instr_count), 0);
        chk("reset step_overrun", int'(step_overrun), 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 27; i++) apply(tbl[i], $sformatf("tbl[%0d]", i));

        // Single-step: pulses during FETCH/EXEC are dropped, S_IDLE between.
        for (int j = 0; j < 2; j++) begin
            for (int g = 0; g < 3; g++) cyc(0,0,0,0,0, 0,PI,0,7+j,0, "ss idle");
            cyc(0,1,0,0,0, 0,PF,0,7+j,0, "ss pulse");
            cyc(0,1,0,0,0, 1,PF,0,7+j,0, "ss drop fetch");
            cyc(0,0,0,0,0, 2,PE,0,7+j,0, "ss exec2");
            cyc(0,1,0,0,0, 3,PE,0,7+j,0, "ss drop exec");
            cyc(0,0,1,0,0, 0,PI,1,8+j,0, "ss retire");
            cyc(0,0,0,0,0, 0,PI,0,8+j,0, "ss no queue");
        end

        // Overrun: no decode_last; run_mode toggled mid-instruction.
        cyc(1,0,0,0,0, 0,PF,0,9,0, "ovr f0");
        cyc(1,0,0,0,0, 1,PF,0,9,0, "ovr f1");
        cyc(1,0,0,0,0, 2,PE,0,9,0, "ovr e2");
        cyc(0,0,0,0,0, 3,PE,0,9,0, "ovr e3");
        cyc(0,0,0,0,0, 4,PE,0,9,0, "ovr e4");
        cyc(1,0,0,0,0, 5,PE,0,9,0, "ovr e5");
        cyc(1,0,0,0,0, 6,PE,0,9,0, "ovr e6");
        cyc(1,0,0,0,0, 7,PE,0,9,0, "ovr e7");
        cyc(1,0,0,0,0, 0,PF,1,10,1, "ovr forced end");
        cyc(1,0,0,0,0, 1,PF,0,10,1, "ovr next f1");
        cyc(1,0,0,0,0, 2,PE,0,10,1, "ovr next e2");
        cyc(0,0,1,0,0, 0,PI,1,11,1, "ovr sticky");

        // Asynchronous reset while in S_EXEC at step 3.
        cyc(1,0,0,0,0, 0,PF,0,11,1, "rst f0");
        cyc(1,0,0,0,0, 1,PF,0,11,1, "rst f1");
        cyc(1,0,0,0,0, 2,PE,0,11,1, "rst e2");
        cyc(0,0,0,0,0, 3,PE,0,11,1, "rst e3");
        rst_n = 1'b0;
        #1;
        chk("midrst step_out", int'(step_out), 0);
        chk("midrst phase_exec", int'(phase_exec), 0);
        chk("midrst instr_count", int'(instr_count), 0);
        chk("midrst step_overrun", int'(step_overrun), 0);
        chk("midrst small_count", int'(s_count), 0);
        @(posedge clk);
        #1;
        chk("midrst instr_done", int'(instr_done), 0);
        chk("midrst held state", int'({phase_fetch, phase_exec, halted}), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Twenty NOPs: the 4-bit instance saturates at 15 but keeps pulsing.
        done_tally = 0;
        cyc(1,0,0,0,0, 0,PF,0,0,0, "sat f0");
        for (int n = 1; n <= 20; n++) begin
            cyc(1,0,0,0,0, 1,PF,0,n-1,0, "sat f1");
            cyc(1,0,0,0,0, 2,PE,0,n-1,0, "sat e2");
            cyc((n < 20), 0, 1, 0, 0, 0, (n < 20) ? PF : PI, 1, n, 0, "sat retire");
        end
        chk("sat done pulses", done_tally, 20);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
